// File: rtl/tx_mac.sv
// 10G Ethernet transmit MAC, 32-bit XGMII side.
// Takes frames (DA..payload) from AXI-Stream, frames them with start,
// preamble and SFD, pads to 60 bytes, appends the CRC-32 FCS, terminates
// and enforces a minimum inter-frame gap. Every XGMII output is registered
// and the whole pipeline freezes while the PCS is not ready.
module tx_mac #(
    parameter int AXIS_DATA_WIDTH  = 32,
    parameter int AXIS_DATA_BYTES  = AXIS_DATA_WIDTH / 8,
    parameter int XGMII_DATA_WIDTH = 32,
    parameter int XGMII_DATA_BYTES = XGMII_DATA_WIDTH / 8,
    parameter int MIN_IFG_WORDS    = 3
) (
    input  logic                        tx_clk,
    input  logic                        tx_rst,
    input  logic [AXIS_DATA_WIDTH-1:0]  in_slave_tx_tdata,
    input  logic [AXIS_DATA_BYTES-1:0]  in_slave_tx_tkeep,
    input  logic                        in_slave_tx_tvalid,
    input  logic                        in_slave_tx_tlast,
    output logic                        out_slave_tx_tready,
    output logic [XGMII_DATA_WIDTH-1:0] out_xgmii_data,
    output logic [XGMII_DATA_BYTES-1:0] out_xgmii_ctl,
    input  logic                        in_xgmii_pcs_ready,
    output logic                        tx_frame_done,
    output logic                        tx_underrun
);

    localparam logic [31:0] IDLE_WORD  = 32'h0707_0707;
    localparam logic [31:0] START_WORD = 32'h5555_55FB;
    localparam logic [31:0] SFD_WORD   = 32'hD555_5555;
    localparam logic [31:0] ERR_WORD   = 32'hFEFE_FEFE;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [6:0]  MIN_BYTES  = 7'd60;
    // MIN_IFG_WORDS is expected to be at least 1.
    localparam int          IFG_W      = (MIN_IFG_WORDS > 1) ? $clog2(MIN_IFG_WORDS) : 1;
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(MIN_IFG_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SFD, S_DATA, S_PAD, S_FCS, S_TERM, S_IFG
    } state_t;

    state_t           state_reg, state_next;
    logic [31:0]      out_data_reg, data_next;
    logic [3:0]       out_ctl_reg, ctl_next;
    logic             done_reg, done_next;
    logic             underrun_reg, underrun_next;
    logic [31:0]      crc_reg, crc_next;
    logic [6:0]       cnt_reg, cnt_next;          // bytes so far, saturates at 64
    logic [IFG_W-1:0] ifg_reg, ifg_next;
    logic [31:0]      resid_reg, resid_next;      // FCS bytes left for the terminate word
    logic [1:0]       resid_lanes_reg, resid_lanes_next;

    // Serial-equivalent reflected CRC-32, one byte per enabled lane.
    function automatic logic [31:0] crc32_upd(input logic [31:0] crc_in,
                                              input logic [31:0] data,
                                              input logic [3:0]  keep);
        logic [31:0] c;
        c = crc_in;
        for (int b = 0; b < 4; b++) begin
            if (keep[b]) begin
                c = c ^ {24'h0, data[8*b +: 8]};
                for (int i = 0; i < 8; i++)
                    c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return c;
    endfunction

    function automatic logic [6:0] cnt_add(input logic [6:0] c, input logic [2:0] n);
        logic [7:0] s;
        s = {1'b0, c} + {5'b0, n};
        return (s > 8'd64) ? 7'd64 : s[6:0];
    endfunction

    logic [3:0]  beat_keep;
    logic [2:0]  beat_bytes;
    logic [2:0]  resid_bytes;
    logic [31:0] beat_mask, data_masked;
    logic [31:0] crc_beat, crc_fill, crc_pad, fcs_beat;
    logic [31:0] merged_word, resid_calc;
    logic [31:0] term_data;
    logic [3:0]  term_ctl;
    logic [6:0]  cnt_beat, cnt_fill, cnt_pad;
    logic        long_partial;

    // Decode last-beat byte enables; anything not a legal prefix (incl. 0000) is one byte.
    always_comb begin
        beat_keep  = 4'b1111;
        beat_bytes = 3'd4;
        if (in_slave_tx_tlast) begin
            case (in_slave_tx_tkeep)
                4'b1111: begin beat_keep = 4'b1111; beat_bytes = 3'd4; end
                4'b0111: begin beat_keep = 4'b0111; beat_bytes = 3'd3; end
                4'b0011: begin beat_keep = 4'b0011; beat_bytes = 3'd2; end
                default: begin beat_keep = 4'b0001; beat_bytes = 3'd1; end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign beat_mask[8*gi +: 8] = {8{beat_keep[gi]}};
            // Residual FCS bytes below the FD lane, idles above it.
            assign term_data[8*gi +: 8] = (LANE < resid_lanes_reg) ? resid_reg[8*gi +: 8] :
                                          ((LANE == resid_lanes_reg) ? 8'hFD : 8'h07);
            assign term_ctl[gi]         = (LANE >= resid_lanes_reg);
        end
    endgenerate

    assign data_masked  = in_slave_tx_tdata & beat_mask;
    assign crc_beat     = crc32_upd(crc_reg, in_slave_tx_tdata, beat_keep);
    assign crc_fill     = crc32_upd(crc_reg, data_masked, 4'b1111);
    assign crc_pad      = crc32_upd(crc_reg, 32'h0, 4'b1111);
    assign fcs_beat     = ~crc_beat;
    assign resid_bytes  = 3'd4 - beat_bytes;
    assign merged_word  = data_masked | (fcs_beat << {beat_bytes[1:0], 3'b000});
    assign resid_calc   = fcs_beat >> {resid_bytes[1:0], 3'b000};
    assign cnt_beat     = cnt_add(cnt_reg, beat_bytes);
    assign cnt_fill     = cnt_add(cnt_reg, 3'd4);
    assign cnt_pad      = cnt_fill;
    // A short last beat of a frame already at minimum size carries FCS bytes itself.
    assign long_partial = (beat_bytes != 3'd4) && (cnt_beat >= MIN_BYTES);

    assign out_slave_tx_tready = in_xgmii_pcs_ready && (state_reg == S_DATA);

    // State and output registers; everything holds while the PCS stalls.
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state_reg       <= S_IDLE;
            out_data_reg    <= IDLE_WORD;
            out_ctl_reg     <= 4'b1111;
            done_reg        <= 1'b0;
            underrun_reg    <= 1'b0;
            crc_reg         <= CRC_INIT;
            cnt_reg         <= 7'd0;
            ifg_reg         <= '0;
            resid_reg       <= 32'h0;
            resid_lanes_reg <= 2'd0;
        end else if (in_xgmii_pcs_ready) begin
            state_reg       <= state_next;
            out_data_reg    <= data_next;
            out_ctl_reg     <= ctl_next;
            done_reg        <= done_next;
            underrun_reg    <= underrun_next;
            crc_reg         <= crc_next;
            cnt_reg         <= cnt_next;
            ifg_reg         <= ifg_next;
            resid_reg       <= resid_next;
            resid_lanes_reg <= resid_lanes_next;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (in_slave_tx_tvalid) state_next = S_START;
            S_START: state_next = S_SFD;
            S_SFD:   state_next = S_DATA;
            S_DATA: begin
                if (!in_slave_tx_tvalid)     state_next = S_IFG;
                else if (in_slave_tx_tlast) begin
                    if (long_partial)           state_next = S_TERM;
                    else if (cnt_fill < MIN_BYTES) state_next = S_PAD;
                    else                        state_next = S_FCS;
                end
            end
            S_PAD:   state_next = (cnt_pad < MIN_BYTES) ? S_PAD : S_FCS;
            S_FCS:   state_next = S_TERM;
            S_TERM:  state_next = S_IFG;
            S_IFG:   if (ifg_reg == IFG_LAST) state_next = in_slave_tx_tvalid ? S_START : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output word and datapath updates for the word produced this cycle.
    always_comb begin
        data_next        = IDLE_WORD;
        ctl_next         = 4'b1111;
        done_next        = 1'b0;
        underrun_next    = 1'b0;
        crc_next         = crc_reg;
        cnt_next         = cnt_reg;
        ifg_next         = ifg_reg;
        resid_next       = resid_reg;
        resid_lanes_next = resid_lanes_reg;
        case (state_reg)
            S_START: begin
                data_next = START_WORD;
                ctl_next  = 4'b0001;
                crc_next  = CRC_INIT;
                cnt_next  = 7'd0;
            end
            S_SFD: begin
                data_next = SFD_WORD;
                ctl_next  = 4'b0000;
            end
            S_DATA: begin
                if (!in_slave_tx_tvalid) begin
                    data_next     = ERR_WORD;
                    underrun_next = 1'b1;
                    crc_next      = CRC_INIT;
                    ifg_next      = '0;
                end else begin
                    ctl_next = 4'b0000;
                    if (!in_slave_tx_tlast) begin
                        data_next = in_slave_tx_tdata;
                        crc_next  = crc_beat;
                        cnt_next  = cnt_beat;
                    end else if (long_partial) begin
                        data_next        = merged_word;
                        crc_next         = CRC_INIT;
                        resid_next       = resid_calc;
                        resid_lanes_next = beat_bytes[1:0];
                    end else begin
                        // Full last beat, or short frame: unused lanes become pad bytes.
                        data_next        = data_masked;
                        crc_next         = crc_fill;
                        cnt_next         = cnt_fill;
                        resid_lanes_next = 2'd0;
                    end
                end
            end
            S_PAD: begin
                data_next = 32'h0;
                ctl_next  = 4'b0000;
                crc_next  = crc_pad;
                cnt_next  = cnt_pad;
            end
            S_FCS: begin
                data_next        = ~crc_reg;
                ctl_next         = 4'b0000;
                crc_next         = CRC_INIT;
                resid_lanes_next = 2'd0;
            end
            S_TERM: begin
                data_next        = term_data;
                ctl_next         = term_ctl;
                done_next        = 1'b1;
                ifg_next         = '0;
                resid_lanes_next = 2'd0;
            end
            S_IFG: begin
                ifg_next = ifg_reg + 1'b1;
            end
            default: ;
        endcase
    end

    assign out_xgmii_data = out_data_reg;
    assign out_xgmii_ctl  = out_ctl_reg;
    assign tx_frame_done  = done_reg;
    assign tx_underrun    = underrun_reg;

endmodule

// File: tb/tb_tx_mac.sv
// Directed bench for tx_mac: frame lengths covering every FD lane, short
// frames with padding, illegal tkeep on tlast, back-to-back IFG, PCS stall,
// underrun and reset mid-frame.
module tb_tx_mac;

    logic        tx_clk = 1'b0;
    logic        tx_rst = 1'b1;
    logic [31:0] in_slave_tx_tdata = 32'h0;
    logic [3:0]  in_slave_tx_tkeep = 4'h0;
    logic        in_slave_tx_tvalid = 1'b0;
    logic        in_slave_tx_tlast = 1'b0;
    logic        out_slave_tx_tready;
    logic [31:0] out_xgmii_data;
    logic [3:0]  out_xgmii_ctl;
    logic        in_xgmii_pcs_ready = 1'b1;
    logic        tx_frame_done;
    logic        tx_underrun;

    int vectors = 0;
    int miscompares = 0;
    bit zero_keep_last = 1'b0;
    // {underrun, done, ctl[3:0], data[31:0]} of every word the PCS accepts
    logic [37:0] q[$];

    localparam logic [35:0] W_START = {4'b0001, 32'h5555_55FB};
    localparam logic [35:0] W_SFD   = {4'b0000, 32'hD555_5555};
    localparam logic [35:0] W_IDLE  = {4'b1111, 32'h0707_0707};
    localparam logic [35:0] W_ERR   = {4'b1111, 32'hFEFE_FEFE};

    always #5 tx_clk = ~tx_clk;

    tx_mac dut (
        .tx_clk              (tx_clk),
        .tx_rst              (tx_rst),
        .in_slave_tx_tdata   (in_slave_tx_tdata),
        .in_slave_tx_tkeep   (in_slave_tx_tkeep),
        .in_slave_tx_tvalid  (in_slave_tx_tvalid),
        .in_slave_tx_tlast   (in_slave_tx_tlast),
        .out_slave_tx_tready (out_slave_tx_tready),
        .out_xgmii_data      (out_xgmii_data),
        .out_xgmii_ctl       (out_xgmii_ctl),
        .in_xgmii_pcs_ready  (in_xgmii_pcs_ready),
        .tx_frame_done       (tx_frame_done),
        .tx_underrun         (tx_underrun)
    );

    always @(negedge tx_clk)
        if (!tx_rst && in_xgmii_pcs_ready)
            q.push_back({tx_underrun, tx_frame_done, out_xgmii_ctl, out_xgmii_data});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge tx_clk);
        #1;
    endtask

    function automatic logic [7:0] pbyte(input int seed, input int idx);
        return 8'((seed + idx) % 256);
    endfunction

    function automatic logic [31:0] beat_data(input int len, input int seed, input int b);
        logic [31:0] d;
        for (int l = 0; l < 4; l++)
            d[8*l +: 8] = (4*b + l < len) ? pbyte(seed, 4*b + l) : 8'hAA;
        return d;
    endfunction

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    // abort_after >= 0: after that beat is accepted, drop tvalid (underrun) or assert reset.
    task automatic send_frame(input int len, input int seed, input bit hold,
                              input int abort_after, input bit abort_rst, input int stall_after);
        int nbeats, b, guard, rem;
        nbeats = (len + 3) / 4;
        b = 0;
        guard = 0;
        while (b < nbeats && guard < 2000) begin
            rem = len - 4*b;
            in_slave_tx_tvalid = 1'b1;
            in_slave_tx_tdata  = beat_data(len, seed, b);
            in_slave_tx_tlast  = (b == nbeats - 1);
            in_slave_tx_tkeep  = (rem >= 4) ? 4'hF : (zero_keep_last ? 4'h0 : 4'((1 << rem) - 1));
            @(negedge tx_clk);
            guard++;
            if (out_slave_tx_tready) begin
                cycle();
                if (b == stall_after) begin
                    in_xgmii_pcs_ready = 1'b0;
                    for (int s = 0; s < 5; s++) begin
                        @(negedge tx_clk);
                        chk("stall data", 64'(out_xgmii_data), 64'(beat_data(len, seed, b)));
                        chk("stall ctl", 64'(out_xgmii_ctl), 64'(4'h0));
                        chk("stall tready", 64'(out_slave_tx_tready), 64'(1'b0));
                        cycle();
                    end
                    in_xgmii_pcs_ready = 1'b1;
                end
                if (b == abort_after) begin
                    in_slave_tx_tvalid = 1'b0;
                    in_slave_tx_tlast  = 1'b0;
                    if (abort_rst) tx_rst = 1'b1;
                    return;
                end
                b++;
            end else begin
                cycle();
            end
        end
        chk("beats accepted", 64'(b), 64'(nbeats));
        if (!hold) begin
            in_slave_tx_tvalid = 1'b0;
            in_slave_tx_tlast  = 1'b0;
        end
    endtask

    task automatic check_frame(input string tag, input int len, input int seed,
                               input int exp_fd_lane, input int from, output int after);
        int i, w, fd_lane, fd_word, bad_pay, bad_pad, done_cnt, idle_cnt, exp_total;
        logic [7:0]  bytes[$];
        logic [31:0] crc;
        logic        tail_ok;
        i = from;
        after = q.size();
        while (i < q.size() && q[i][35:0] !== W_START) i++;
        chk({tag, " start"}, 64'(i < q.size()), 64'(1'b1));
        if (i + 1 >= q.size()) return;
        chk({tag, " sfd"}, 64'(q[i+1][35:0]), 64'(W_SFD));
        w = i + 2;
        fd_lane = -1;
        fd_word = -1;
        tail_ok = 1'b1;
        while (w < q.size() && fd_word < 0) begin
            for (int l = 0; l < 4; l++) begin
                if (fd_word >= 0) begin
                    if (!(q[w][32+l] && q[w][8*l +: 8] == 8'h07)) tail_ok = 1'b0;
                end else if (q[w][32+l]) begin
                    fd_word = w;
                    fd_lane = (q[w][8*l +: 8] == 8'hFD) ? l : -2;
                end else begin
                    bytes.push_back(q[w][8*l +: 8]);
                end
            end
            w++;
        end
        chk({tag, " fd lane"}, 64'(fd_lane), 64'(exp_fd_lane));
        if (fd_word < 0) return;
        exp_total = ((len < 60) ? 60 : len) + 4;
        chk({tag, " byte count"}, 64'(bytes.size()), 64'(exp_total));
        bad_pay = 0;
        bad_pad = 0;
        for (int j = 0; j < bytes.size() && j < 60; j++) begin
            if (j < len && bytes[j] !== pbyte(seed, j)) bad_pay++;
            if (j >= len && bytes[j] !== 8'h00) bad_pad++;
        end
        chk({tag, " payload errors"}, 64'(bad_pay), 64'(0));
        chk({tag, " pad errors"}, 64'(bad_pad), 64'(0));
        crc = 32'hFFFF_FFFF;
        foreach (bytes[j]) crc = crc_byte(crc, bytes[j]);
        chk({tag, " crc residue"}, 64'(crc), 64'(32'hDEBB_20E3));
        chk({tag, " done on FD word"}, 64'(q[fd_word][36]), 64'(1'b1));
        done_cnt = 0;
        for (int k = i; k < fd_word; k++) if (q[k][36] || q[k][37]) done_cnt++;
        chk({tag, " early done/underrun"}, 64'(done_cnt), 64'(0));
        chk({tag, " idle after FD"}, 64'(tail_ok), 64'(1'b1));
        idle_cnt = 0;
        for (int k = fd_word + 1; k <= fd_word + 3 && k < q.size(); k++)
            if (q[k][35:0] === W_IDLE) idle_cnt++;
        chk({tag, " ifg words"}, 64'(idle_cnt), 64'(3));
        after = fd_word + 1;
    endtask

    int lens[6]  = '{64, 65, 62, 63, 20, 59};
    int lanes[6] = '{0, 1, 2, 3, 0, 0};

    initial begin
        int a1, a2, st, dc, ic;
        repeat (3) cycle();
        chk("reset data", 64'(out_xgmii_data), 64'(32'h0707_0707));
        chk("reset ctl", 64'(out_xgmii_ctl), 64'(4'hF));
        chk("reset tready", 64'(out_slave_tx_tready), 64'(1'b0));
        chk("reset done", 64'(tx_frame_done), 64'(1'b0));
        chk("reset underrun", 64'(tx_underrun), 64'(1'b0));
        tx_rst = 1'b0;
        cycle();

        // Lengths chosen so the FD byte lands in every lane, plus padded frames.
        for (int t = 0; t < 6; t++) begin
            q.delete();
            send_frame(lens[t], 16*t + 1, 1'b0, -1, 1'b0, -1);
            repeat (30) cycle();
            check_frame($sformatf("len%0d", lens[t]), lens[t], 16*t + 1, lanes[t], 0, a1);
        end

        // tkeep=0 on tlast counts as one byte: 61-byte frame.
        q.delete();
        zero_keep_last = 1'b1;
        send_frame(61, 200, 1'b0, -1, 1'b0, -1);
        zero_keep_last = 1'b0;
        repeat (30) cycle();
        check_frame("keep0", 61, 200, 1, 0, a1);

        // Back-to-back frames with tvalid held high.
        q.delete();
        send_frame(66, 7, 1'b1, -1, 1'b0, -1);
        send_frame(24, 90, 1'b0, -1, 1'b0, -1);
        repeat (40) cycle();
        check_frame("b2b first", 66, 7, 2, 0, a1);
        chk("b2b start after ifg", 64'(q[a1+3][35:0]), 64'(W_START));
        check_frame("b2b second", 24, 90, 0, a1, a2);

        // PCS stall during DATA.
        q.delete();
        send_frame(48, 33, 1'b0, -1, 1'b0, 5);
        repeat (30) cycle();
        check_frame("stall", 48, 33, 0, 0, a1);

        // Underrun after four beats.
        q.delete();
        send_frame(40, 50, 1'b0, 3, 1'b0, -1);
        repeat (15) cycle();
        st = 0;
        while (st < q.size() && q[st][35:0] !== W_START) st++;
        chk("underrun start", 64'(st < q.size()), 64'(1'b1));
        for (int b = 0; b < 4; b++)
            chk($sformatf("underrun beat%0d", b), 64'(q[st+2+b][35:0]), 64'({4'h0, beat_data(40, 50, b)}));
        chk("underrun word", 64'(q[st+6][35:0]), 64'(W_ERR));
        chk("underrun pulse", 64'(q[st+6][37]), 64'(1'b1));
        dc = 0;
        ic = 0;
        for (int k = st; k < q.size(); k++) if (q[k][36]) dc++;
        for (int k = st + 7; k <= st + 9 && k < q.size(); k++) if (q[k][35:0] === W_IDLE) ic++;
        chk("underrun no done", 64'(dc), 64'(0));
        chk("underrun ifg", 64'(ic), 64'(3));

        // Reset in the middle of DATA, then a clean frame.
        q.delete();
        send_frame(80, 60, 1'b0, 4, 1'b1, -1);
        cycle();
        chk("midrst data", 64'(out_xgmii_data), 64'(32'h0707_0707));
        chk("midrst ctl", 64'(out_xgmii_ctl), 64'(4'hF));
        chk("midrst tready", 64'(out_slave_tx_tready), 64'(1'b0));
        chk("midrst done", 64'(tx_frame_done), 64'(1'b0));
        tx_rst = 1'b0;
        cycle();
        chk("post rst data", 64'(out_xgmii_data), 64'(32'h0707_0707));
        chk("post rst ctl", 64'(out_xgmii_ctl), 64'(4'hF));
        q.delete();
        send_frame(70, 61, 1'b0, -1, 1'b0, -1);
        repeat (30) cycle();
        check_frame("after rst", 70, 61, 2, 0, a1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
